float_multi_pipe: RTL

Parametrised, fully pipelined IEEE-754-style floating-point multiplier. It is the successor to float_multi, generalised to any exponent and mantissa width.
- Accepts one operand pair per cycle through a valid/ready handshake.
- Result appears after a fixed 3-stage latency, with full backpressure.
- Rounding is round-to-nearest-even; subnormals are flushed to zero.
- Sits in the arithmetic datapath between operand FIFOs and result consumers.

---
 rtl/float_pkg.sv | 46 ++++
 rtl/float_round_pack.sv | 76 +++++++
 rtl/float_multi_pipe.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/float_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | float_pkg                                                        |
// | Shared types and helpers for the pipelined float multiplier.     |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package float_pkg;

  // Operand / result classification.
  typedef enum logic [2:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_QNAN,
    FP_SNAN
  } fp_class_e;

  // Bit positions inside the 5-bit flags word.
  localparam int c_flag_inexact   = 0;
  localparam int c_flag_underflow = 1;
  localparam int c_flag_overflow  = 2;
  localparam int c_flag_div0      = 3;
  localparam int c_flag_invalid   = 4;
  localparam int c_flag_w         = 5;

  // Widest word the NaN helper can build.
  localparam int c_max_w = 128;

  // Exponent bias for an exponent field of exp_w bits.
  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB only.
  function automatic logic [c_max_w-1:0] canon_nan(input int exp_w, input int man_w);
    logic [c_max_w-1:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) begin
      v[man_w + i] = 1'b1;
    end
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/float_round_pack.sv
`default_nettype none
// +------------------------------------------------------------------+
// | float_round_pack                                                 |
// | Final stage logic: round-to-nearest-even, range check, special   |
// | case substitution and packing into sign|exp|frac.                |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module float_round_pack
  import float_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     sign,
  input  logic signed [EXP_W+1:0]  exp,
  input  logic [MAN_W:0]           man,
  input  logic                     guard,
  input  logic                     sticky,
  input  fp_class_e                cls,
  input  logic                     invalid,
  output logic [EXP_W+MAN_W:0]     word,
  output logic [c_flag_w-1:0]      flags
);

  localparam int c_w  = 1 + EXP_W + MAN_W;
  localparam int c_xw = EXP_W + 2;
  localparam logic signed [c_xw-1:0] c_emax = c_xw'((1 << EXP_W) - 1);
  localparam logic signed [c_xw-1:0] c_one  = c_xw'(1);
  localparam logic signed [c_xw-1:0] c_zero = '0;
  localparam logic [c_w-1:0]         c_nan  = c_w'(canon_nan(EXP_W, MAN_W));

  logic                    w_inc;
  logic [MAN_W+1:0]        w_sum;
  logic                    w_carry;
  logic [MAN_W-1:0]        w_frac;
  logic signed [c_xw-1:0]  w_expf;
  logic                    w_inexact;

  assign w_inc     = guard & (sticky | man[0]);
  assign w_sum     = {1'b0, man} + {{(MAN_W+1){1'b0}}, w_inc};
  // A carry out of the mantissa means it rolled over to 2.0: frac becomes 0.
  assign w_carry   = w_sum[MAN_W+1];
  assign w_frac    = w_carry ? '0 : w_sum[MAN_W-1:0];
  assign w_expf    = exp + (w_carry ? c_one : c_zero);
  assign w_inexact = guard | sticky;

  // Select the packed result and flags by class, then by exponent range.
  always_comb begin
    word  = '0;
    flags = '0;
    case (cls)
      FP_QNAN: begin
        word                  = c_nan;
        flags[c_flag_invalid] = invalid;
      end
      FP_INF:  word = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      FP_ZERO: word = {sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
      default: begin
        if (w_expf >= c_emax) begin
          word                   = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags[c_flag_overflow] = 1'b1;
          flags[c_flag_inexact]  = 1'b1;
        end else if (w_expf <= c_zero) begin
          word                    = {sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
          flags[c_flag_underflow] = 1'b1;
          flags[c_flag_inexact]   = 1'b1;
        end else begin
          word                  = {sign, w_expf[EXP_W-1:0], w_frac};
          flags[c_flag_inexact] = w_inexact;
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/float_multi_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | float_multi_pipe                                                 |
// | Three-stage floating-point multiplier with valid/ready flow      |
// | control, RNE rounding and flush-to-zero of subnormals.           |
// | Optional: FLOAT_MULTI_FLAGS_EN adds the 5-bit flags output.      |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module float_multi_pipe
  import float_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   z
`ifdef FLOAT_MULTI_FLAGS_EN
  ,
  output logic [c_flag_w-1:0]    flags
`endif
);

  localparam int c_w  = 1 + EXP_W + MAN_W;
  localparam int c_xw = EXP_W + 2;
  localparam int c_pw = 2 * MAN_W + 2;
  localparam logic signed [c_xw-1:0] c_bias = c_xw'(bias(EXP_W));
  localparam logic signed [c_xw-1:0] c_one  = c_xw'(1);

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0) return FP_ZERO;
    if (e == '1) begin
      if (f == '0) return FP_INF;
      return f[MAN_W-1] ? FP_QNAN : FP_SNAN;
    end
    return FP_NORM;
  endfunction

  // Flow control: each stage loads when empty or when its successor takes its content.
  logic r1_valid, r2_valid, r3_valid;
  logic w_ld1, w_ld2, w_ld3;
  assign w_ld3     = ~r3_valid | out_ready;
  assign w_ld2     = ~r2_valid | w_ld3;
  assign w_ld1     = ~r1_valid | w_ld2;
  assign in_ready  = w_ld1;
  assign out_valid = r3_valid;

  // Stage 1 combinational: classify, exponent sum, mantissa product.
  logic [EXP_W-1:0]        w_ea, w_eb;
  logic [MAN_W-1:0]        w_fa, w_fb;
  fp_class_e               w_ca, w_cb, w_cls1;
  logic                    w_infzero, w_inv1;
  logic signed [c_xw-1:0]  w_exp1;
  logic [c_pw-1:0]         w_prod1;

  assign w_ea      = a[c_w-2:MAN_W];
  assign w_eb      = b[c_w-2:MAN_W];
  assign w_fa      = a[MAN_W-1:0];
  assign w_fb      = b[MAN_W-1:0];
  assign w_ca      = classify(w_ea, w_fa);
  assign w_cb      = classify(w_eb, w_fb);
  assign w_infzero = (w_ca == FP_INF && w_cb == FP_ZERO) || (w_ca == FP_ZERO && w_cb == FP_INF);
  assign w_exp1    = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - c_bias;
  assign w_prod1   = {{(MAN_W+1){1'b0}}, 1'b1, w_fa} * {{(MAN_W+1){1'b0}}, 1'b1, w_fb};

  // Resolve special operands in priority order: NaN / inf*0, then inf, then zero.
  always_comb begin
    w_cls1 = FP_NORM;
    w_inv1 = 1'b0;
    if (w_ca == FP_QNAN || w_ca == FP_SNAN || w_cb == FP_QNAN || w_cb == FP_SNAN || w_infzero) begin
      w_cls1 = FP_QNAN;
      w_inv1 = (w_ca == FP_SNAN) || (w_cb == FP_SNAN) || w_infzero;
    end else if (w_ca == FP_INF || w_cb == FP_INF) begin
      w_cls1 = FP_INF;
    end else if (w_ca == FP_ZERO || w_cb == FP_ZERO) begin
      w_cls1 = FP_ZERO;
    end
  end

  logic                    r1_sign;
  logic signed [c_xw-1:0]  r1_exp;
  logic [c_pw-1:0]         r1_prod;
  fp_class_e               r1_cls;

  // Stage 1 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r1_sign  <= 1'b0;
      r1_exp   <= '0;
      r1_prod  <= '0;
      r1_cls   <= FP_ZERO;
    end else if (w_ld1) begin
      r1_valid <= in_valid;
      r1_sign  <= a[c_w-1] ^ b[c_w-1];
      r1_exp   <= w_exp1;
      r1_prod  <= w_prod1;
      r1_cls   <= w_cls1;
    end
  end

  // Stage 2 combinational: normalise so the mantissa lies in [1,2).
  logic [MAN_W:0]          w_man2;
  logic                    w_guard2, w_sticky2;
  logic signed [c_xw-1:0]  w_exp2;

  always_comb begin
    if (r1_prod[c_pw-1]) begin
      w_man2    = r1_prod[c_pw-1:MAN_W+1];
      w_guard2  = r1_prod[MAN_W];
      w_sticky2 = |r1_prod[MAN_W-1:0];
      w_exp2    = r1_exp + c_one;
    end else begin
      w_man2    = r1_prod[c_pw-2:MAN_W];
      w_guard2  = r1_prod[MAN_W-1];
      w_sticky2 = |r1_prod[MAN_W-2:0];
      w_exp2    = r1_exp;
    end
  end

  logic                    r2_sign, r2_guard, r2_sticky;
  logic signed [c_xw-1:0]  r2_exp;
  logic [MAN_W:0]          r2_man;
  fp_class_e               r2_cls;

  // Stage 2 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_valid  <= 1'b0;
      r2_sign   <= 1'b0;
      r2_exp    <= '0;
      r2_man    <= '0;
      r2_guard  <= 1'b0;
      r2_sticky <= 1'b0;
      r2_cls    <= FP_ZERO;
    end else if (w_ld2) begin
      r2_valid  <= r1_valid;
      r2_sign   <= r1_sign;
      r2_exp    <= w_exp2;
      r2_man    <= w_man2;
      r2_guard  <= w_guard2;
      r2_sticky <= w_sticky2;
      r2_cls    <= r1_cls;
    end
  end

  // Stage 3 combinational: round and pack.
  logic [c_w-1:0]       w_z3;
  logic [c_flag_w-1:0]  w_flags3;
  logic                 w_inv2;

  float_round_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_pack (
    .sign    (r2_sign),
    .exp     (r2_exp),
    .man     (r2_man),
    .guard   (r2_guard),
    .sticky  (r2_sticky),
    .cls     (r2_cls),
    .invalid (w_inv2),
    .word    (w_z3),
    .flags   (w_flags3)
  );

  logic [c_w-1:0] r3_z;

  // Stage 3 register: the output holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r3_valid <= 1'b0;
      r3_z     <= '0;
    end else if (w_ld3) begin
      r3_valid <= r2_valid;
      r3_z     <= w_z3;
    end
  end

  assign z = r3_z;

`ifdef FLOAT_MULTI_FLAGS_EN
  logic                 r1_inv, r2_inv;
  logic [c_flag_w-1:0]  r3_flags;

  // Invalid tag and flags travel in lockstep with the data stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_inv   <= 1'b0;
      r2_inv   <= 1'b0;
      r3_flags <= '0;
    end else begin
      if (w_ld1) r1_inv   <= w_inv1;
      if (w_ld2) r2_inv   <= r1_inv;
      if (w_ld3) r3_flags <= w_flags3;
    end
  end

  assign w_inv2 = r2_inv;
  assign flags  = r3_flags;
`else
  // Without the flags port the invalid tag has no consumer.
  logic w_unused_flags;
  assign w_inv2         = 1'b0;
  assign w_unused_flags = ^{w_inv1, w_flags3};
`endif

endmodule
`default_nettype wire
